// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with set mode and seven-segment outputs.
// Optional display blink in set mode: define BCD_BLINK_EN.
module bcd_mod_counter #(
  parameter int MOD       = 24,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       modify,
  input  logic       add,
  input  logic       sub,
  output logic [3:0] value_ones,
  output logic [3:0] value_tens,
  output logic       carry_out,
  output logic [7:0] display0,
  output logic [7:0] display1
);

  if (MOD < 2 || MOD > 100) begin : g_bad_mod
    $error("bcd_mod_counter: MOD must be 2..100");
  end

  if (BLINK_DIV < 1) begin : g_bad_div
    $error("bcd_mod_counter: BLINK_DIV must be >= 1");
  end

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       carry_q, carry_d;
  logic       inc, dec;
  logic       at_max, at_zero;
  logic       blank;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h02;
      4'd1:    s = 8'h9E;
      4'd2:    s = 8'h24;
      4'd3:    s = 8'h0C;
      4'd4:    s = 8'h98;
      4'd5:    s = 8'h48;
      4'd6:    s = 8'h40;
      4'd7:    s = 8'h1E;
      4'd8:    s = 8'h00;
      4'd9:    s = 8'h08;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign inc     = modify ? (add & ~sub) : tick;
  assign dec     = modify & sub & ~add;
  assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Next digits and carry; carry only on a tick-driven wrap.
  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    carry_d = 1'b0;
    unique case (1'b1)
      inc: begin
        if (at_max) begin
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          carry_d = ~modify;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      dec: begin
        if (at_zero) begin
          tens_d = MAX_T;
          ones_d = MAX_O;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
      default: begin
        tens_d = tens_q;
      end
    endcase
  end

  // Counter and carry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      carry_q <= carry_d;
    end
  end

`ifdef BCD_BLINK_EN
  localparam int CW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLAST =
    CW'(BLINK_DIV - 1);

  logic [CW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Blink divider; held in the on phase outside set mode.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!modify) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BLAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank = modify & ~phase_q;
`else
  assign blank = 1'b0;
`endif

  assign value_tens = tens_q;
  assign value_ones = ones_q;
  assign carry_out  = carry_q;

  assign display0 = blank ? 8'hFF : seg(ones_q);
  assign display1 = blank ? 8'hFF
                          : (seg(tens_q) | 8'h01);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter (MOD=24 and MOD=60).
// Blink checks run when BCD_BLINK_EN is defined.
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       modify = 1'b0;
  logic       add = 1'b0;
  logic       sub = 1'b0;

  logic [3:0] o24, t24, o60, t60;
  logic       c24, c60;
  logic [7:0] a0, a1, b0, b1;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  bcd_mod_counter #(.MOD(24), .BLINK_DIV(4)) u24 (
    .clk(clk), .rst(rst), .tick(tick),
    .modify(modify), .add(add), .sub(sub),
    .value_ones(o24), .value_tens(t24),
    .carry_out(c24),
    .display0(a0), .display1(a1)
  );

  bcd_mod_counter #(.MOD(60), .BLINK_DIV(4)) u60 (
    .clk(clk), .rst(rst), .tick(tick),
    .modify(modify), .add(add), .sub(sub),
    .value_ones(o60), .value_tens(t60),
    .carry_out(c60),
    .display0(b0), .display1(b1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic t, m, a, s;
    int   et, eo, ec, e0, e1;
  } vec_t;

  vec_t tbl[16];
  int   segt[10];

  task automatic chk(input string nm,
                     input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic m,
                      input logic a, input logic s);
    @(negedge clk);
    tick = t; modify = m; add = a; sub = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0; modify = 0; add = 0; sub = 0;
    rst = 0;
    #2;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic chk24(input string nm, input int n,
                       input int c);
    chk({nm, "_t24"}, t24, n / 10);
    chk({nm, "_o24"}, o24, n % 10);
    chk({nm, "_c24"}, c24, c);
    chk({nm, "_d0"}, a0, segt[n % 10]);
    chk({nm, "_d1"}, a1, segt[n / 10] | 1);
  endtask

  task automatic chk60(input string nm, input int n,
                       input int c);
    chk({nm, "_t60"}, t60, n / 10);
    chk({nm, "_o60"}, o60, n % 10);
    chk({nm, "_c60"}, c60, c);
    chk({nm, "_e0"}, b0, segt[n % 10]);
  endtask

  initial begin
    int n24, n60, w24, w60;
    segt = '{'h02, 'h9E, 'h24, 'h0C, 'h98,
             'h48, 'h40, 'h1E, 'h00, 'h08};
    tbl[0]  = '{0,1,0,1, 2,3,0,'h0C,'h25};
    tbl[1]  = '{0,1,1,0, 0,0,0,'h02,'h03};
    tbl[2]  = '{1,1,0,0, 0,0,0,'h02,'h03};
    tbl[3]  = '{0,1,1,0, 0,1,0,'h9E,'h03};
    tbl[4]  = '{0,1,1,1, 0,1,0,'h9E,'h03};
    tbl[5]  = '{0,0,1,0, 0,1,0,'h9E,'h03};
    tbl[6]  = '{0,0,0,1, 0,1,0,'h9E,'h03};
    tbl[7]  = '{1,0,0,0, 0,2,0,'h24,'h03};
    tbl[8]  = '{1,1,0,0, 0,2,0,'h24,'h03};
    tbl[9]  = '{0,1,0,1, 0,1,0,'h9E,'h03};
    tbl[10] = '{0,1,0,1, 0,0,0,'h02,'h03};
    tbl[11] = '{0,1,0,1, 2,3,0,'h0C,'h25};
    tbl[12] = '{1,0,0,0, 0,0,1,'h02,'h03};
    tbl[13] = '{0,0,0,0, 0,0,0,'h02,'h03};
    tbl[14] = '{0,1,1,0, 0,1,0,'h9E,'h03};
    tbl[15] = '{0,0,0,0, 0,1,0,'h9E,'h03};

    #3;
    chk("rst_t24", t24, 0);
    chk("rst_o24", o24, 0);
    chk("rst_c24", c24, 0);
    chk("rst_d0", a0, 'h02);
    chk("rst_d1", a1, 'h03);
    @(negedge clk);
    rst = 1;

    n24 = 0; n60 = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0, 0);
      w24 = (n24 == 23);
      w60 = (n60 == 59);
      n24 = w24 ? 0 : n24 + 1;
      n60 = w60 ? 0 : n60 + 1;
      chk24($sformatf("tick%0d", i), n24, w24);
      chk60($sformatf("tick%0d", i), n60, w60);
    end
    step(0, 0, 0, 0);
    chk("idle_c24", c24, 0);
    chk("idle_c60", c60, 0);

    do_reset();
    for (int i = 1; i <= 17; i++) step(1, 0, 0, 0);
    chk24("pre17", 17, 0);
    #2;
    rst = 0;
    #1;
    chk24("async", 0, 0);
    chk60("async", 0, 0);
    @(negedge clk);
    rst = 1;

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].t, tbl[i].m, tbl[i].a, tbl[i].s);
      chk($sformatf("v%0d_t", i), t24, tbl[i].et);
      chk($sformatf("v%0d_o", i), o24, tbl[i].eo);
      chk($sformatf("v%0d_c", i), c24, tbl[i].ec);
      chk($sformatf("v%0d_d0", i), a0, tbl[i].e0);
      chk($sformatf("v%0d_d1", i), a1, tbl[i].e1);
    end

    do_reset();
    step(0, 1, 0, 1);
    chk60("sub00", 59, 0);
    step(0, 1, 1, 0);
    chk60("add59", 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 0, 0, 0);
    chk60("ten", 10, 0);
    step(0, 1, 0, 1);
    chk60("borrow", 9, 0);
    chk("borrow_d1", b1, 'h03);

`ifdef BCD_BLINK_EN
    do_reset();
    @(negedge clk);
    modify = 1;
    #1;
    chk("blink0_d0", a0, 'h02);
    chk("blink0_d1", a1, 'h03);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (((k / 4) % 2) == 0) begin
        chk($sformatf("blink%0d_d0", k), a0, 'h02);
        chk($sformatf("blink%0d_d1", k), a1, 'h03);
      end else begin
        chk($sformatf("blink%0d_d0", k), a0, 'hFF);
        chk($sformatf("blink%0d_d1", k), a1, 'hFF);
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    modify = 0;
    #1;
    chk("unblink_d0", a0, 'h02);
    chk("unblink_d1", a1, 'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised two-digit BCD modulo counter with seven-segment outputs. It is the generic building block for the digital clock's seconds, minutes and hours stages; MOD sets the wrap point, e.g. 60 for seconds and minutes, 24 for hours. Stages chain by feeding one stage's carry_out into the next stage's tick. Adds a decrement path, a set mode with guarded add/sub, and a registered carry output.

Parameters:
MOD, 24, count modulus; the counter holds 0..MOD-1; legal range 2..100, anything else is an elaboration $error
BLINK_DIV, 25000000, blink half-period in clk cycles; used only when BCD_BLINK_EN is defined; must be >= 1

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
tick  input  1  single-cycle count pulse from the lower stage's carry or from a timebase
modify  input  1  level; 1 = set mode
add  input  1  single-cycle pulse, step up (set mode only; already debounced upstream)
sub  input  1  single-cycle pulse, step down (set mode only)
value_ones  output  4  registered BCD ones digit
value_tens  output  4  registered BCD tens digit
carry_out  output  1  registered wrap pulse, drives the next stage's tick
display0  output  8  ones-digit segments {a,b,c,d,e,f,g,dp}, active-low, dp lit
display1  output  8  tens-digit segments, active-low, dp dark

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge):
  - value_tens=0, value_ones=0, carry_out=0, blink phase = on.
  - display0=0x02, display1=0x03.
- Step decode, evaluated each cycle:
  - inc = modify ? (add & ~sub) : tick
  - dec = modify & sub & ~add
  - modify=1 with add=sub=1: hold.
  - tick is ignored while modify=1.
  - add and sub are ignored while modify=0.
- Increment:
  - ones 9 -> 0 and tens+1; otherwise ones+1.
  - When value == MOD-1, the next value is 00.
- Decrement:
  - ones 0 -> 9 and tens-1; otherwise ones-1.
  - 00 -> MOD-1, with digits taken from the BCD of MOD-1 (MOD=100 gives 99).
  - No borrow output.
- carry_out:
  - Registered; 1 for exactly one cycle, coinciding with the first cycle the counter reads 00 after a tick-driven wrap.
  - Never asserted on a set-mode wrap or on a decrement.
  - 0 in every other cycle.
- Latency: one clock edge from a sampled tick/add/sub to the updated value and carry_out. Displays are combinational decodes of the registered digits, so there are no extra cycles.
- Segment decode for display0, digits 0..9: 0x02, 0x9E, 0x24, 0x0C, 0x98, 0x48, 0x40, 0x1E, 0x00, 0x08.
- display1 uses the same decode OR 0x01 (dp dark); its digit-0 value is 0x03.
- Any non-BCD digit decodes to 0xFF. This is unreachable in normal operation.
- Toggling modify never changes the value by itself.
- A tick arriving in the same cycle modify falls is ignored (modify is sampled high).
- Counter state is never outside 0..MOD-1.

Optional Feature:
Macro BCD_BLINK_EN.
- Defined:
  - A free-running blink counter, cleared while modify=0 and on reset, toggles the blink phase every BLINK_DIV cycles while modify=1.
  - In the off phase, display0 and display1 are both forced to 0xFF.
  - Entering set mode always starts in the on phase.
  - The value path and carry_out are unaffected.
- Not defined:
  - No blink logic is present; BLINK_DIV is unused.
  - Displays always show the decoded value.

Test Plan:
1. rst=0 asserted mid-count at value 17, no clock edge -> value 00 immediately, carry_out=0, display0=0x02, display1=0x03.
2. MOD=24, 23 tick pulses from 00 -> value 23, display1=0x25, display0=0x0C, carry_out=0 throughout; 24th tick -> 00 with carry_out=1 for exactly one cycle.
3. MOD=60, 9 ticks -> 09 (display0=0x08); 10th tick -> 10 (tens=1, ones=0); 59 ticks total then one more -> 00 with carry_out pulse.
4. MOD=24, modify=1: sub at 00 -> 23; add at 23 -> 00 with carry_out=0; tick pulses during modify -> no change.
5. modify=1, add=sub=1 for one cycle -> hold; modify=0 with add pulse -> hold.
6. BCD_BLINK_EN defined, BLINK_DIV=4, modify=1 -> valid digits for 4 cycles, 0xFF for 4 cycles, repeating; modify=0 -> steady digits immediately.
